// File: rtl/card_select_ctrl.sv
// Card-select sequencer: synchronizes and debounces the 16-switch bank, decodes a one-hot
// card index and issues it on a confirm press. Optional macro CARD_MASK_EN adds avail_mask.
module card_select_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CNT_W           = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel_en,
  input  logic [15:0] switch,
  input  logic        btn_confirm,
  input  logic        sel_ready,
`ifdef CARD_MASK_EN
  input  logic [15:0] avail_mask,
`endif
  output logic        sel_valid,
  output logic [3:0]  sel_idx,
  output logic        sel_err,
  output logic        sel_armed
);

  localparam int unsigned SW_W  = 16;
  localparam int unsigned IDX_W = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_ARMED,
    S_ERR,
    S_ISSUE,
    S_WAIT_REL
  } state_e;

  state_e           state_q;
  logic [SW_W-1:0]  sw_s1_q, sw_sync_q, sw_prev_q;
  logic             btn_s1_q, btn_sync_q, btn_prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sel_valid_q, sel_err_q, sel_armed_q;
  logic [IDX_W-1:0] sel_idx_q;

  logic             sw_change_c, stable_c, btn_rise_c;
  logic             one_hot_c, legal_c, mask_change_c;
  logic [IDX_W-1:0] dec_idx_c;

  assign sw_change_c = (sw_sync_q != sw_prev_q);
  assign btn_rise_c  = btn_sync_q & ~btn_prev_q;
  // A count left over from the previous pattern must not qualify a freshly changed one.
  assign stable_c    = (cnt_q == CNT_W'(DEBOUNCE_CYCLES)) && !sw_change_c;

  // Debounce counter: clear on change, count up and saturate while unchanged.
  always_comb begin
    cnt_d = cnt_q;
    if (sw_change_c) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_W'(DEBOUNCE_CYCLES)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // One-hot decode of the synchronized pattern.
  always_comb begin
    dec_idx_c = '0;
    for (int i = 0; i < SW_W; i++) begin
      if (sw_sync_q[i]) dec_idx_c = IDX_W'(i);
    end
  end

  assign one_hot_c = (sw_sync_q != '0) && ((sw_sync_q & (sw_sync_q - SW_W'(1))) == '0);

`ifdef CARD_MASK_EN
  logic [SW_W-1:0] mask_prev_q;

  always_ff @(posedge clk) begin
    if (rst) mask_prev_q <= '0;
    else     mask_prev_q <= avail_mask;
  end

  assign legal_c       = one_hot_c && avail_mask[dec_idx_c];
  assign mask_change_c = one_hot_c && (avail_mask[dec_idx_c] != mask_prev_q[dec_idx_c]);
`else
  assign legal_c       = one_hot_c;
  assign mask_change_c = 1'b0;
`endif

  // Synchronizers, debounce state and the selection FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      sw_s1_q     <= '0;
      sw_sync_q   <= '0;
      sw_prev_q   <= '0;
      btn_s1_q    <= 1'b0;
      btn_sync_q  <= 1'b0;
      btn_prev_q  <= 1'b0;
      cnt_q       <= '0;
      sel_valid_q <= 1'b0;
      sel_err_q   <= 1'b0;
      sel_armed_q <= 1'b0;
      sel_idx_q   <= '0;
    end else begin
      sw_s1_q     <= switch;
      sw_sync_q   <= sw_s1_q;
      sw_prev_q   <= sw_sync_q;
      btn_s1_q    <= btn_confirm;
      btn_sync_q  <= btn_s1_q;
      btn_prev_q  <= btn_sync_q;
      cnt_q       <= cnt_d;
      sel_valid_q <= 1'b0;
      sel_err_q   <= 1'b0;
      sel_armed_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (sel_en) state_q <= S_SETTLE;
        end
        S_SETTLE: begin
          if (!sel_en) begin
            state_q <= S_IDLE;
          end else if (stable_c) begin
            if (legal_c) begin
              state_q     <= S_ARMED;
              sel_armed_q <= 1'b1;
              sel_idx_q   <= dec_idx_c;
            end else begin
              state_q   <= S_ERR;
              sel_err_q <= 1'b1;
            end
          end
        end
        S_ARMED: begin
          if (!sel_en) begin
            state_q <= S_IDLE;
          end else if (sw_change_c || mask_change_c) begin
            state_q <= S_SETTLE;
          end else if (btn_rise_c) begin
            state_q     <= S_ISSUE;
            sel_valid_q <= 1'b1;
          end else begin
            sel_armed_q <= 1'b1;
          end
        end
        S_ERR: begin
          if (!sel_en) begin
            state_q <= S_IDLE;
          end else if (sw_change_c || mask_change_c) begin
            state_q <= S_SETTLE;
          end else begin
            sel_err_q <= 1'b1;
          end
        end
        S_ISSUE: begin
          if (sel_valid_q && sel_ready) begin
            state_q <= S_WAIT_REL;
          end else begin
            sel_valid_q <= 1'b1;
          end
        end
        S_WAIT_REL: begin
          // Hold here until the button is released so one press yields one transfer.
          if (!btn_sync_q) state_q <= sel_en ? S_SETTLE : S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign sel_valid = sel_valid_q;
  assign sel_idx   = sel_idx_q;
  assign sel_err   = sel_err_q;
  assign sel_armed = sel_armed_q;

endmodule

// File: tb/tb_card_select_ctrl.sv
// Directed bench for card_select_ctrl with a short debounce window (4 cycles).
module tb_card_select_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel_en;
  logic [15:0] switch;
  logic        btn_confirm;
  logic        sel_ready;
  logic        sel_valid;
  logic [3:0]  sel_idx;
  logic        sel_err;
  logic        sel_armed;
`ifdef CARD_MASK_EN
  logic [15:0] avail_mask;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  int xfer_cnt = 0;
  logic [3:0] last_xfer_idx = 4'd0;

  card_select_ctrl #(.DEBOUNCE_CYCLES(4), .CNT_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .sel_en     (sel_en),
    .switch     (switch),
    .btn_confirm(btn_confirm),
    .sel_ready  (sel_ready),
`ifdef CARD_MASK_EN
    .avail_mask (avail_mask),
`endif
    .sel_valid  (sel_valid),
    .sel_idx    (sel_idx),
    .sel_err    (sel_err),
    .sel_armed  (sel_armed)
  );

  always #5 clk = ~clk;

  // Handshake transfers as seen at the active edge.
  always @(posedge clk) begin
    if (!rst && sel_valid && sel_ready) begin
      xfer_cnt      <= xfer_cnt + 1;
      last_xfer_idx <= sel_idx;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // which: 0 = sel_armed, 1 = sel_err, 2 = sel_valid
  task automatic wait_for(input string tag, input int which, input int limit);
    bit got = 1'b0;
    for (int n = 0; n < limit && !got; n++) begin
      tick();
      case (which)
        0:       got = sel_armed;
        1:       got = sel_err;
        default: got = sel_valid;
      endcase
    end
    chk(tag, 16'(got), 16'd1);
  endtask

  task automatic pulse_btn();
    btn_confirm = 1'b1;
    tick();
    tick();
    btn_confirm = 1'b0;
  endtask

  initial begin
    int base;
    bit bad;

    rst = 1'b1;
    sel_en = 1'($urandom_range(0, 1));
    switch = 16'($urandom);
    btn_confirm = 1'($urandom_range(0, 1));
    sel_ready = 1'($urandom_range(0, 1));
`ifdef CARD_MASK_EN
    avail_mask = 16'hFFFF;
`endif
    tick();
    tick();
    chk("rst_valid", 16'(sel_valid), 16'd0);
    chk("rst_idx",   16'(sel_idx),   16'd0);
    chk("rst_err",   16'(sel_err),   16'd0);
    chk("rst_armed", 16'(sel_armed), 16'd0);

    // Basic selection, stalled issue, single transfer.
    rst = 1'b0; sel_en = 1'b1; switch = 16'h0020; btn_confirm = 1'b0; sel_ready = 1'b0;
    wait_for("arm_5", 0, 20);
    chk("idx_5", 16'(sel_idx), 16'd5);
    chk("no_valid_armed", 16'(sel_valid), 16'd0);
    pulse_btn();
    wait_for("valid_rise", 2, 6);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_valid", 16'(sel_valid), 16'd1);
      chk("stall_idx", 16'(sel_idx), 16'd5);
    end
    chk("no_xfer_stall", 16'(xfer_cnt), 16'd0);
    sel_ready = 1'b1;
    tick();
    chk("valid_fall", 16'(sel_valid), 16'd0);
    chk("one_xfer", 16'(xfer_cnt), 16'd1);
    chk("xfer_idx", 16'(last_xfer_idx), 16'd5);
    sel_ready = 1'b0;

    // Illegal multi-bit pattern: error, confirm ignored.
    switch = 16'h0028;
    wait_for("err_multi", 1, 20);
    chk("err_not_armed", 16'(sel_armed), 16'd0);
    sel_ready = 1'b1;
    bad = 1'b0;
    btn_confirm = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 2) btn_confirm = 1'b0;
      if (sel_valid || !sel_err) bad = 1'b1;
    end
    chk("err_ignores_btn", 16'(bad), 16'd0);
    chk("err_no_xfer", 16'(xfer_cnt), 16'd1);
    sel_ready = 1'b0;

    switch = 16'h8000;
    wait_for("arm_15", 0, 20);
    chk("err_cleared", 16'(sel_err), 16'd0);
    chk("idx_15", 16'(sel_idx), 16'd15);
    switch = 16'h0000;
    wait_for("err_zero", 1, 20);
    chk("zero_not_armed", 16'(sel_armed), 16'd0);
    chk("idx_retained", 16'(sel_idx), 16'd15);

    // Bouncing switches never settle.
    bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      switch = ((i / 2) % 2 == 0) ? 16'h0001 : 16'h0002;
      tick();
      if (i >= 4 && (sel_armed || sel_err)) bad = 1'b1;
    end
    chk("bounce_quiet", 16'(bad), 16'd0);
    switch = 16'h0002;
    wait_for("arm_1", 0, 20);
    chk("idx_1", 16'(sel_idx), 16'd1);

    // Held button yields one transfer; a fresh press yields another.
    base = xfer_cnt;
    sel_ready = 1'b1;
    btn_confirm = 1'b1;
    for (int i = 0; i < 25; i++) tick();
    chk("held_one_xfer", 16'(xfer_cnt - base), 16'd1);
    chk("held_no_valid", 16'(sel_valid), 16'd0);
    chk("held_not_armed", 16'(sel_armed), 16'd0);
    btn_confirm = 1'b0;
    wait_for("rearm", 0, 20);
    pulse_btn();
    for (int i = 0; i < 6; i++) tick();
    chk("second_xfer", 16'(xfer_cnt - base), 16'd2);
    chk("second_idx", 16'(last_xfer_idx), 16'd1);
    sel_ready = 1'b0;

    // sel_en drop in ARMED.
    wait_for("arm_pre_en", 0, 20);
    sel_en = 1'b0;
    tick();
    chk("en_drop_armed", 16'(sel_armed), 16'd0);
    tick();
    tick();
    chk("idle_stays", 16'(sel_armed | sel_err | sel_valid), 16'd0);
    sel_en = 1'b1;
    wait_for("arm_after_en", 0, 20);

    // Reset while issuing.
    pulse_btn();
    wait_for("valid_pre_rst", 2, 6);
    rst = 1'b1;
    tick();
    chk("rst_issue_valid", 16'(sel_valid), 16'd0);
    chk("rst_issue_idx", 16'(sel_idx), 16'd0);
    rst = 1'b0;

`ifdef CARD_MASK_EN
    avail_mask = 16'hFFF7;
    switch = 16'h0008;
    wait_for("mask_err", 1, 20);
    chk("mask_not_armed", 16'(sel_armed), 16'd0);
    avail_mask = 16'hFFFF;
    wait_for("mask_rearm", 0, 20);
    chk("mask_idx", 16'(sel_idx), 16'd3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/card_select_ctrl.md
Name: card_select_ctrl

Overview:
Sequences the 16-position card-select switch bank for the card register path. Synchronizes and debounces the raw switches, then decodes a one-hot pattern to a 4-bit card index. Arms on a clean selection and issues the index to the card register on a confirm button press, using a valid/ready handshake. Sits between the board switches/button and the card register load logic, gated by the game FSM through sel_en.

Parameters:
- DEBOUNCE_CYCLES, 50000: consecutive unchanged synchronized samples required before the switch pattern counts as stable. Minimum 1.
- CNT_W, 16: debounce counter width. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk, input, 1: system clock; all logic is on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- sel_en, input, 1: game FSM permits a selection.
- switch, input, 16: raw, asynchronous switch bank.
- btn_confirm, input, 1: raw, asynchronous confirm button, active high.
- sel_ready, input, 1: consumer accepts the index.
- sel_valid, output, 1: index offered to the consumer.
- sel_idx, output, 4: selected card index.
- sel_err, output, 1: stable pattern is not a legal selection.
- sel_armed, output, 1: legal stable selection, waiting for confirm (LED drive).

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE, sel_valid=0, sel_idx=0, sel_err=0, sel_armed=0, debounce counter=0, synchronizers=0. rst overrides all other inputs, including in ISSUE.
- switch and btn_confirm each pass through a 2-flop synchronizer.
- Confirm edge: btn_rise = btn_sync & ~btn_prev.
- Debounce: the counter clears whenever sw_sync differs from its previous sample. Otherwise it increments and saturates at DEBOUNCE_CYCLES.
  - stable = (count == DEBOUNCE_CYCLES).
  - sw_change = (sw_sync != previous sample).
- Decode: a stable pattern with exactly one bit set at position k is legal, with idx = k. An all-zero or multi-bit pattern is illegal.
- States and transitions:
  - IDLE: all outputs 0. sel_en=1 → SETTLE.
  - SETTLE: wait for stable. When stable: legal → ARMED and latch idx into sel_idx; illegal → ERR.
  - ARMED: sel_armed=1. sw_change → SETTLE with sel_armed=0 next cycle. btn_rise → ISSUE. If both occur in the same cycle, sw_change wins.
  - ERR: sel_err=1. btn_rise is ignored. sw_change → SETTLE with sel_err=0 next cycle.
  - ISSUE: sel_valid=1 and sel_idx held constant. A transfer occurs on a cycle where sel_valid & sel_ready, then → WAIT_REL. sel_valid must not drop before the transfer. sel_en and switch changes are ignored in ISSUE.
  - WAIT_REL: wait until btn_sync=0. Then → SETTLE if sel_en=1, else → IDLE. This blocks a held button from re-issuing.
- sel_en=0 in SETTLE, ARMED or ERR → IDLE on the next edge.
- Latency:
  - sel_valid rises on the edge after the cycle where btn_rise=1 in ARMED.
  - sel_valid falls on the edge after the transfer cycle.
  - At most one transfer per button press.
- sel_idx retains its last latched value in every state except reset.

Optional Feature:
- Macro: CARD_MASK_EN.
- Defined:
  - Adds input avail_mask[15:0], 1 = card available. It is sampled directly, not synchronized.
  - A one-hot pattern at bit k with avail_mask[k]=0 is illegal → ERR.
  - A change of avail_mask[k] for the current selection while in ARMED or ERR → SETTLE.
- Undefined: the port is absent and every one-hot pattern is legal.

Test Plan:
- Reset: hold rst 2 cycles with random inputs → sel_valid=0, sel_idx=0, sel_err=0, sel_armed=0.
- DEBOUNCE_CYCLES=4, sel_en=1, switch=16'h0020 held; pulse btn; hold sel_ready=0 for 3 cycles, then 1 → sel_armed=1; sel_valid=1 with sel_idx=5 constant through the stall; exactly one transfer; sel_valid=0 the following cycle.
- switch=16'h0028, then pulse btn → sel_err=1 and no sel_valid. Change to 16'h8000 → sel_err=0, sel_armed=1, sel_idx=15. switch=0 → sel_err=1.
- Bounce: toggle switch between 16'h0001 and 16'h0002 every 2 cycles for 40 cycles → sel_armed and sel_err never assert. Then hold 16'h0002 → armed, idx=1.
- Hold btn high across the transfer and through 20 cycles → single transfer. After release and a new press → second transfer.
- Control and mask cases:
  - sel_en drops in ARMED → IDLE, sel_armed=0 next cycle.
  - rst mid-ISSUE → sel_valid=0 next cycle.
  - With CARD_MASK_EN, avail_mask=16'hFFF7 and switch=16'h0008 → sel_err=1.
